// File: rtl/fft_pkg.sv
// Shared widths, FSM state type and twiddle tables for the 8-point streaming FFT.
// Twiddles are cos/-sin of 2*pi*m/8 scaled by 256 and rounded to the nearest integer.
package fft_pkg;
  localparam int N_POINTS  = 8;
  localparam int SAMPLE_W  = 4;
  localparam int BIN_W     = 64;
  localparam int FFT_IN_W  = 32;
  localparam int FFT_OUT_W = 512;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

  function automatic logic signed [31:0] tw_cos(input logic [2:0] idx);
    case (idx)
      3'd0:    return 32'sd256;
      3'd1:    return 32'sd181;
      3'd2:    return 32'sd0;
      3'd3:    return -32'sd181;
      3'd4:    return -32'sd256;
      3'd5:    return -32'sd181;
      3'd6:    return 32'sd0;
      default: return 32'sd181;
    endcase
  endfunction

  function automatic logic signed [31:0] tw_nsin(input logic [2:0] idx);
    case (idx)
      3'd0:    return 32'sd0;
      3'd1:    return -32'sd181;
      3'd2:    return -32'sd256;
      3'd3:    return -32'sd181;
      3'd4:    return 32'sd0;
      3'd5:    return 32'sd181;
      3'd6:    return 32'sd256;
      default: return 32'sd181;
    endcase
  endfunction
endpackage

// File: rtl/fft_stream_ctrl_fft.sv
// Combinational 8-point DFT of unsigned 4-bit samples; bin k = {re[31:0], im[31:0]}
// at out[511-64k -: 64], evaluated directly as sum x[n]*W^(n*k).
module fastFourierTransform
  import fft_pkg::*;
(
  input  logic [FFT_IN_W-1:0]  in,
  output logic [FFT_OUT_W-1:0] out
);
  logic signed [31:0] w_x  [N_POINTS];
  logic signed [31:0] w_re [N_POINTS];
  logic signed [31:0] w_im [N_POINTS];

  always_comb begin
    for (int n = 0; n < N_POINTS; n++) begin
      w_x[n] = $signed({{(32-SAMPLE_W){1'b0}}, in[FFT_IN_W-1-SAMPLE_W*n -: SAMPLE_W]});
    end
  end

  always_comb begin
    out = '0;
    for (int k = 0; k < N_POINTS; k++) begin
      w_re[k] = '0;
      w_im[k] = '0;
      for (int n = 0; n < N_POINTS; n++) begin
        // n*k mod 8 selects the twiddle; truncation to 3 bits is the modulo
        w_re[k] = w_re[k] + w_x[n] * tw_cos(3'(n * k));
        w_im[k] = w_im[k] + w_x[n] * tw_nsin(3'(n * k));
      end
      out[FFT_OUT_W-1-BIN_W*k -: BIN_W] = {w_re[k], w_im[k]};
    end
  end
endmodule

// File: rtl/fft_stream_ctrl.sv
// Streaming wrapper: gathers 8 samples, lets the combinational FFT settle,
// then streams the 8 bins out with valid/ready backpressure.
module fft_stream_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [BIN_W-1:0]    m_data,
  output logic [IDX_W-1:0]    m_index,
  output logic                m_last,
  output logic                busy,
  output logic                frame_done,
  output state_t              state
);
  // Handshake: a beat moves only on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the offered bin is frozen until it is taken.
  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = 3'(N_POINTS - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       r_wr_cnt, w_wr_cnt_nxt;
  logic [IDX_W-1:0]       r_rd_cnt, w_rd_cnt_nxt;
  logic [IDX_W-1:0]       w_next_idx;
  logic [3:0]             r_settle_cnt, w_settle_nxt;
  logic [FFT_IN_W-1:0]    r_samples;
  logic [FFT_OUT_W-1:0]   r_result;
  logic [FFT_OUT_W-1:0]   w_fft_out;
  logic [BIN_W-1:0]       r_m_data, w_m_data_nxt;
  logic                   r_frame_done, w_done_nxt;
  logic                   w_sample_we, w_result_we;

  fastFourierTransform u_fft (
    .in  (r_samples),
    .out (w_fft_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_cnt_nxt = r_wr_cnt;
    w_rd_cnt_nxt = r_rd_cnt;
    w_settle_nxt = r_settle_cnt;
    w_m_data_nxt = r_m_data;
    w_next_idx   = r_rd_cnt + 3'd1;
    w_sample_we  = 1'b0;
    w_result_we  = 1'b0;
    w_done_nxt   = 1'b0;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    m_last       = 1'b0;
    m_index      = '0;
    case (r_state)
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          w_sample_we  = 1'b1;
          w_wr_cnt_nxt = r_wr_cnt + 3'd1;
          if (r_wr_cnt == LAST_IDX) begin
            w_state_nxt  = ST_SETTLE;
            w_wr_cnt_nxt = '0;
            w_settle_nxt = SETTLE_INIT;
          end
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt == 4'd0) begin
          w_result_we  = 1'b1;
          w_m_data_nxt = w_fft_out[FFT_OUT_W-1 -: BIN_W];
          w_state_nxt  = ST_UNLOAD;
        end else begin
          w_settle_nxt = r_settle_cnt - 4'd1;
        end
      end
      ST_UNLOAD: begin
        m_valid = 1'b1;
        m_index = r_rd_cnt;
        m_last  = (r_rd_cnt == LAST_IDX);
        if (m_ready) begin
          if (r_rd_cnt == LAST_IDX) begin
            // m_data keeps bin 7 until the next frame's bin 0 is captured
            w_rd_cnt_nxt = '0;
            w_state_nxt  = ST_LOAD;
            w_done_nxt   = 1'b1;
          end else begin
            w_rd_cnt_nxt = w_next_idx;
            w_m_data_nxt = r_result[FFT_OUT_W-1-BIN_W*int'(w_next_idx) -: BIN_W];
          end
        end
      end
      default: begin
        w_state_nxt  = ST_LOAD;
        w_wr_cnt_nxt = '0;
        w_rd_cnt_nxt = '0;
        w_settle_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      r_settle_cnt <= '0;
      r_samples    <= '0;
      r_result     <= '0;
      r_m_data     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_cnt     <= w_wr_cnt_nxt;
      r_rd_cnt     <= w_rd_cnt_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_m_data     <= w_m_data_nxt;
      r_frame_done <= w_done_nxt;
      if (w_sample_we) r_samples[FFT_IN_W-1-SAMPLE_W*int'(r_wr_cnt) -: SAMPLE_W] <= s_data;
      if (w_result_we) r_result <= w_fft_out;
    end
  end

  assign m_data     = r_m_data;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != ST_LOAD) || (r_wr_cnt != '0);
  assign state      = r_state;
endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Directed and randomized frames against a DFT reference computed with real cos/sin.
module tb_fft_stream_ctrl;
  import fft_pkg::*;

  localparam int SC = 1;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic [2:0]  m_index;
  logic        m_last;
  logic        busy;
  logic        frame_done;
  state_t      state;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] gold [8];

  fft_stream_ctrl #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .m_last(m_last), .busy(busy),
    .frame_done(frame_done), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference: X[k] = sum x[n] * exp(-j*2*pi*n*k/8), twiddles scaled by 256 and rounded
  task automatic compute_gold(input logic [31:0] word);
    for (int k = 0; k < 8; k++) begin
      int re;
      int im;
      re = 0;
      im = 0;
      for (int n = 0; n < 8; n++) begin
        int  x;
        real ang;
        x   = int'(word[31-4*n -: 4]);
        ang = 2.0 * 3.14159265358979 * real'(n * k) / 8.0;
        re  = re + x * int'(256.0 * $cos(ang));
        im  = im + x * int'(-256.0 * $sin(ang));
      end
      gold[k] = {32'(re), 32'(im)};
    end
  endtask

  // rdy_mode: 0 = always ready, 1 = stall bin bp_bin for 4 cycles, 2 = random ready
  task automatic run_frame(input logic [31:0] word, input bit gaps, input bit overlap,
                           input int rdy_mode, input int bp_bin);
    int sent, cyc, wait_cyc, bin, stall, guard;
    logic [63:0] prev_data;
    logic [2:0]  prev_idx;
    bit          was_stall;
    compute_gold(word);
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(gold[k]);
    m_ready = 1'b1;
    sent = 0;
    cyc  = 0;
    while (sent < 8 && cyc < 64) begin
      s_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      s_data  = word[31-4*sent -: 4];
      @(negedge clk);
      chk("load_s_ready", 64'(s_ready), 64'(1'b1));
      chk("load_m_valid", 64'(m_valid), 64'(1'b0));
      chk("load_busy", 64'(busy), 64'(sent != 0));
      @(posedge clk);
      if (s_valid) sent++;
      #1;
      cyc++;
    end
    chk("load_count", 64'(sent), 64'(8));
    s_valid = overlap;
    s_data  = 4'($urandom_range(0, 15));
    wait_cyc = 0;
    @(negedge clk);
    while (!m_valid && wait_cyc < 20) begin
      chk("settle_s_ready", 64'(s_ready), 64'(1'b0));
      chk("settle_busy", 64'(busy), 64'(1'b1));
      chk("settle_m_index", 64'(m_index), 64'(0));
      wait_cyc++;
      @(posedge clk);
      #1;
      s_data = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    chk("latency", 64'(wait_cyc), 64'(SC));
    bin = 0;
    stall = 0;
    guard = 0;
    was_stall = 1'b0;
    prev_data = '0;
    prev_idx  = '0;
    while (bin < 8 && guard < 64) begin
      chk("m_valid", 64'(m_valid), 64'(1'b1));
      chk("m_index", 64'(m_index), 64'(bin));
      chk("m_last", 64'(m_last), 64'(bin == 7));
      chk("m_data", m_data, exp_q[0]);
      chk("unload_s_ready", 64'(s_ready), 64'(1'b0));
      if (was_stall) begin
        chk("stall_data", m_data, prev_data);
        chk("stall_index", 64'(m_index), 64'(prev_idx));
      end
      if (rdy_mode == 1 && bin == bp_bin && stall < 4) begin
        m_ready = 1'b0;
        stall++;
      end else if (rdy_mode == 2) begin
        m_ready = 1'($urandom_range(0, 1));
      end else begin
        m_ready = 1'b1;
      end
      prev_data = m_data;
      prev_idx  = m_index;
      was_stall = !m_ready;
      @(posedge clk);
      if (m_ready) begin
        void'(exp_q.pop_front());
        bin++;
      end
      #1;
      if (overlap) s_data = 4'($urandom_range(0, 15));
      @(negedge clk);
      guard++;
    end
    chk("unload_count", 64'(bin), 64'(8));
    chk("q_empty", 64'(exp_q.size()), 64'(0));
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("frame_done", 64'(frame_done), 64'(1'b1));
    chk("post_m_valid", 64'(m_valid), 64'(1'b0));
    chk("post_state", 64'(state), 64'(ST_LOAD));
    chk("post_s_ready", 64'(s_ready), 64'(1'b1));
    chk("post_m_data_hold", m_data, gold[7]);
    chk("post_m_index", 64'(m_index), 64'(0));
    chk("post_m_last", 64'(m_last), 64'(1'b0));
    chk("post_busy", 64'(busy), 64'(1'b0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("frame_done_pulse", 64'(frame_done), 64'(1'b0));
    chk("post2_m_data_hold", m_data, gold[7]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 4'h0;
    m_ready = 1'b0;
    #3;
    chk("rst_state", 64'(state), 64'(ST_LOAD));
    chk("rst_s_ready", 64'(s_ready), 64'(1'b1));
    chk("rst_m_valid", 64'(m_valid), 64'(1'b0));
    chk("rst_m_last", 64'(m_last), 64'(1'b0));
    chk("rst_m_index", 64'(m_index), 64'(0));
    chk("rst_m_data", m_data, 64'(0));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_frame_done", 64'(frame_done), 64'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_s_ready", 64'(s_ready), 64'(1'b1));
      chk("idle_m_valid", 64'(m_valid), 64'(1'b0));
      chk("idle_busy", 64'(busy), 64'(1'b0));
      @(posedge clk);
      #1;
    end

    run_frame(32'h00000000, 1'b0, 1'b0, 0, -1);
    run_frame(32'h11111111, 1'b0, 1'b0, 0, -1);
    run_frame(32'h01234567, 1'b0, 1'b0, 1, 3);
    run_frame($urandom, 1'b1, 1'b1, 0, -1);

    // abandon a frame after 5 samples with an asynchronous reset
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(1'b0));
    chk("mid_rst_m_data", m_data, 64'(0));
    chk("mid_rst_state", 64'(state), 64'(ST_LOAD));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(32'h22222222, 1'b0, 1'b0, 0, -1);

    for (int f = 0; f < 6; f++) begin
      w = $urandom;
      run_frame(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_stream_ctrl.md
FFT_STREAM_CTRL -- requirements
Module: fft_stream_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: clock cycles allowed for the combinational FFT to settle before its result is captured; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 s_valid  input  1  input sample offered.
REQ-005 s_ready  output  1  controller accepts a sample this cycle.
REQ-006 s_data  input  4  one time-domain sample.
REQ-007 m_valid  output  1  frequency bin offered.
REQ-008 m_ready  input  1  consumer accepts the bin this cycle.
REQ-009 m_data  output  64  one bin: real in [63:32], imaginary in [31:0].
REQ-010 m_index  output  3  bin number of m_data, 0..7.
REQ-011 m_last  output  1  high with bin 7.
REQ-012 busy  output  1  high in any state other than LOAD, or in LOAD with at least one sample held.
REQ-013 frame_done  output  1  one-cycle pulse after bin 7 is accepted.

Function
REQ-014 A transfer SHALL occur only on a cycle with valid and ready both high on the same port.
REQ-015 States SHALL be LOAD, SETTLE and UNLOAD, encoded as a 2-bit value.
REQ-016 In LOAD, s_ready SHALL be 1, and each accepted sample SHALL be written to slot wr_cnt of a 32-bit sample register, with slot k at bits [31-4k:28-4k], after which wr_cnt increments.
REQ-017 The transfer that writes slot 7 SHALL move the state to SETTLE, clear wr_cnt and load the settle counter with SETTLE_CYCLES-1.
REQ-018 In SETTLE and UNLOAD, s_ready SHALL be 0, and the sample register SHALL hold its value and drive the FFT input.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles. On its final cycle, the full 512-bit FFT output SHALL be latched into a result register and the state SHALL move to UNLOAD.
REQ-020 Latency: if the last sample is accepted on the edge at cycle T, m_valid SHALL first be high in cycle T+1+SETTLE_CYCLES.
REQ-021 In UNLOAD, m_valid SHALL be 1. m_data SHALL be result bits [511-64i:448-64i] for i = rd_cnt, and m_index SHALL equal rd_cnt.
REQ-022 While m_valid=1 and m_ready=0, m_data, m_index and m_last SHALL remain stable.
REQ-023 Each output transfer SHALL increment rd_cnt.
REQ-024 The output transfer with rd_cnt=7 SHALL clear rd_cnt, return the state to LOAD and assert frame_done for the following cycle.
REQ-025 Frames SHALL NOT overlap: no sample is accepted from the entry to SETTLE until LOAD is re-entered, and the first new sample is accepted no earlier than the cycle after the last bin transfer.
REQ-026 When outside UNLOAD, m_valid, m_last and m_index SHALL be 0, and m_data SHALL hold its last value.
REQ-027 s_valid while s_ready=0 SHALL be ignored with no state change, and m_ready while m_valid=0 SHALL be ignored.
REQ-028 An unsupported state encoding SHALL recover to LOAD with all counters cleared.

Reset
REQ-029 On rst_n=0, the outputs SHALL immediately become: state LOAD, s_ready=1, m_valid=0, m_last=0, m_index=0, m_data=0, busy=0, frame_done=0.
REQ-030 On rst_n=0, wr_cnt, rd_cnt, the settle counter, the sample register and the result register SHALL be 0.
REQ-031 A reset in any state SHALL discard any partial or unread frame, and the next frame SHALL restart at slot 0 and bin 0.

Structure
REQ-032 A shared package fft_pkg SHALL hold N_POINTS=8, SAMPLE_W=4, BIN_W=64, FFT_IN_W=32, FFT_OUT_W=512 and the state typedef.
REQ-033 The controller SHALL instantiate exactly one fastFourierTransform (ports in, out) as its only sub-module; everything else is flat RTL.

Verification
REQ-034 Reset behaviour: with rst_n=0 then released, and s_valid=0 for 5 cycles, the bench SHALL see s_ready=1, m_valid=0 and busy=0 throughout.
REQ-035 Zero frame: 8 samples 4'h0 with m_ready=1 and SETTLE_CYCLES=1 SHALL give m_valid in cycle T+2, eight bins equal to 64'h0, m_index 0..7, m_last on bin 7 only, and frame_done one cycle after it.
REQ-036 DC frame: samples all 4'h1 SHALL give bins equal to a golden fastFourierTransform driven with in=32'h11111111, bin 0 taken from out[511:448].
REQ-037 Backpressure: ramp samples 0..7 with m_ready held 0 for 4 cycles on bin 3 SHALL keep m_data, m_index=3 and m_last=0 stable, and no bin SHALL be lost or duplicated.
REQ-038 Input gaps and overlap: s_valid toggling 1010... during a frame SHALL still fill slots in order, and s_valid held high in SETTLE/UNLOAD SHALL get s_ready=0 with the sample register unchanged.
REQ-039 Reset mid-frame: rst_n pulsed low after 5 samples, then 8 fresh samples 4'h2, SHALL produce bins matching the golden model for in=32'h22222222.
